// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types: register indices, default widths.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_if.sv
// Register-file port bundle: two read ports, one write port, write counter.
interface reg_file_if #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rs_uninit;
    logic              rt_uninit;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [15:0]       wr_count;

    modport master (
        output rs_addr, rt_addr, we, wr_addr, wr_data,
        input  rs_data, rt_data, rs_uninit, rt_uninit, wr_count
    );

    modport slave (
        input  rs_addr, rt_addr, we, wr_addr, wr_data,
        output rs_data, rt_data, rs_uninit, rt_uninit, wr_count
    );
endinterface

// File: rtl/reg_file_rd_port.sv
// Single combinational read port: reg-0 force, uninit flag, optional write bypass (REGFILE_BYPASS_EN).
// Latency: zero (combinational).
// Backpressure: none; always ready.
module reg_file_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    output logic [DATA_W-1:0] data,
    output logic              uninit,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              written
`ifdef REGFILE_BYPASS_EN
    ,
    input  logic              wr_vld,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
`endif
);

    logic is_zero;
    assign is_zero = (rd_addr == '0);

`ifdef REGFILE_BYPASS_EN
    // wr_vld already excludes index 0 and reset, so a hit is always a real commit.
    logic hit;
    assign hit    = wr_vld && (wr_addr == rd_addr);
    assign data   = is_zero ? '0 : (hit ? wr_data : stored);
    assign uninit = !is_zero && !written && !hit;
`else
    assign data   = is_zero ? '0 : stored;
    assign uninit = !is_zero && !written;
`endif

endmodule

// File: rtl/reg_file.sv
// 32-entry MIPS register file with written-since-reset tracking; REGFILE_BYPASS_EN adds write-through reads.
// Latency: reads combinational, writes commit on rising clk.
// Backpressure: none; every cycle accepts a read pair and an optional write.
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input logic       clk,
    input logic       rst_n,
    reg_file_if.slave rf
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;
    logic [15:0]       wr_count_q;
    logic              commit;

    // Writes to r0 are dropped entirely: no data, bitmap or counter effect.
    assign commit = rf.we && rst_n && (rf.wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            written    <= '0;
            wr_count_q <= '0;
        end else if (commit) begin
            mem[rf.wr_addr]     <= rf.wr_data;
            written[rf.wr_addr] <= 1'b1;
            if (wr_count_q != 16'hFFFF) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign rf.wr_count = wr_count_q;

    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_port (
        .data    (rf.rs_data),
        .uninit  (rf.rs_uninit),
        .rd_addr (rf.rs_addr),
        .stored  (mem[rf.rs_addr]),
        .written (written[rf.rs_addr])
`ifdef REGFILE_BYPASS_EN
        ,
        .wr_vld  (commit),
        .wr_addr (rf.wr_addr),
        .wr_data (rf.wr_data)
`endif
    );

    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_port (
        .data    (rf.rt_data),
        .uninit  (rf.rt_uninit),
        .rd_addr (rf.rt_addr),
        .stored  (mem[rf.rt_addr]),
        .written (written[rf.rt_addr])
`ifdef REGFILE_BYPASS_EN
        ,
        .wr_vld  (commit),
        .wr_addr (rf.wr_addr),
        .wr_data (rf.wr_data)
`endif
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed-vector bench for reg_file; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file;
    import mips_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    reg_file_if #(.DATA_W(32), .ADDR_W(5)) rf ();

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks happen on the falling edge.
    task automatic do_write(input reg_idx_t a, input logic [31:0] d);
        rf.we      = 1'b1;
        rf.wr_addr = a;
        rf.wr_data = d;
        @(posedge clk);
        #1;
        rf.we = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_same;
        logic [31:0] exp_un17;
        logic [31:0] last_d;
        n_vec = 0;
        n_err = 0;
        rst_n      = 1'b0;
        rf.we      = 1'b0;
        rf.wr_addr = '0;
        rf.wr_data = '0;
        rf.rs_addr = '0;
        rf.rt_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset pulse mid-cycle with a write pending.
        rf.we      = 1'b1;
        rf.wr_addr = 5'd5;
        rf.wr_data = 32'hDEADBEEF;
        rf.rs_addr = 5'd5;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_rs_data", rf.rs_data, 32'h0);
        chk("rst_hold_count", {16'h0, rf.wr_count}, 32'h0);
        rf.we = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_r5_data", rf.rs_data, 32'h0);
        chk("rst_r5_uninit", {31'h0, rf.rs_uninit}, 32'h1);
        chk("rst_count", {16'h0, rf.wr_count}, 32'h0);
        rf.rt_addr = 5'd17;
        #1;
        chk("rst_r17_uninit", {31'h0, rf.rt_uninit}, 32'h1);
        @(posedge clk);
        #1;

        // Basic write/read.
        do_write(5'd8, 32'h800C001C);
        do_write(5'd9, 32'h8008001C);
        rf.rs_addr = 5'd8;
        rf.rt_addr = 5'd9;
        @(negedge clk);
        chk("rd_r8", rf.rs_data, 32'h800C001C);
        chk("rd_r9", rf.rt_data, 32'h8008001C);
        chk("rd_r8_uninit", {31'h0, rf.rs_uninit}, 32'h0);
        chk("rd_r9_uninit", {31'h0, rf.rt_uninit}, 32'h0);
        chk("count_2", {16'h0, rf.wr_count}, 32'd2);
        @(posedge clk);
        #1;

        // Register zero discards writes.
        rf.rs_addr = 5'd0;
        do_write(5'd0, 32'hFFFFFFFF);
        @(negedge clk);
        chk("r0_data", rf.rs_data, 32'h0);
        chk("r0_uninit", {31'h0, rf.rs_uninit}, 32'h0);
        chk("r0_count", {16'h0, rf.wr_count}, 32'd2);
        @(posedge clk);
        #1;

        // Same-cycle read/write to r3.
        do_write(5'd3, 32'h2);
        rf.rs_addr = 5'd3;
        rf.we      = 1'b1;
        rf.wr_addr = 5'd3;
        rf.wr_data = 32'h7;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h7;
`else
        exp_same = 32'h2;
`endif
        @(negedge clk);
        chk("r3_same_cycle", rf.rs_data, exp_same);
        @(posedge clk);
        #1;
        rf.we = 1'b0;
        @(negedge clk);
        chk("r3_next_cycle", rf.rs_data, 32'h7);
        chk("count_4", {16'h0, rf.wr_count}, 32'd4);
        @(posedge clk);
        #1;

        // Uninit clears after the first write to r17.
        rf.rt_addr = 5'd17;
        rf.we      = 1'b1;
        rf.wr_addr = 5'd17;
        rf.wr_data = 32'h10;
`ifdef REGFILE_BYPASS_EN
        exp_un17 = 32'h0;
`else
        exp_un17 = 32'h1;
`endif
        @(negedge clk);
        chk("r17_uninit_during_wr", {31'h0, rf.rt_uninit}, exp_un17);
        @(posedge clk);
        #1;
        rf.we = 1'b0;
        @(negedge clk);
        chk("r17_uninit_after", {31'h0, rf.rt_uninit}, 32'h0);
        chk("r17_data", rf.rt_data, 32'h10);
        rf.rs_addr = 5'd17;
        #1;
        chk("same_addr_rs", rf.rs_data, 32'h10);
        chk("same_addr_rt", rf.rt_data, 32'h10);
        chk("count_5", {16'h0, rf.wr_count}, 32'd5);
        @(posedge clk);
        #1;

        // Counter saturation: 65540 further committed writes to r20.
        rf.rs_addr = 5'd20;
        rf.we      = 1'b1;
        rf.wr_addr = 5'd20;
        last_d     = 32'h0;
        for (int i = 0; i < 65540; i++) begin
            last_d     = 32'hA000_0000 + i;
            rf.wr_data = last_d;
            @(posedge clk);
            #1;
            if (i == 65528) begin
                chk("count_fffe", {16'h0, rf.wr_count}, 32'h0000FFFE);
            end else if (i == 65529) begin
                chk("count_ffff", {16'h0, rf.wr_count}, 32'h0000FFFF);
            end
        end
        rf.we = 1'b0;
        @(negedge clk);
        chk("count_hold", {16'h0, rf.wr_count}, 32'h0000FFFF);
        chk("r20_last", rf.rs_data, last_d);
        chk("r20_last_value", rf.rs_data, 32'hA000_FFFF + 32'd4);
        @(posedge clk);
        #1;
        do_write(5'd21, 32'h1234);
        rf.rt_addr = 5'd21;
        @(negedge clk);
        chk("count_hold_more", {16'h0, rf.wr_count}, 32'h0000FFFF);
        chk("r21_data", rf.rt_data, 32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
